// File: rtl/icache_array_pkg.sv
// Geometry and state encoding for the direct-mapped instruction cache.
`include "isa.v"

package icache_array_pkg;

   localparam int unsigned XLEN           = `XLEN;
   localparam int unsigned LINE_WORDS     = `LINE_WORDS;
   localparam int unsigned OFFSET_BITS    = `OFFSET_BITS;
   localparam int unsigned LINE_BYTE_BITS = `LINE_BYTE_BITS;
   localparam int unsigned NUM_LINES      = 16;
   localparam int unsigned IDX_W          = $clog2(NUM_LINES);
   localparam int unsigned TAG_W          = XLEN - LINE_BYTE_BITS - IDX_W;
   localparam int unsigned WORD_LSB       = LINE_BYTE_BITS - OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      REPLAY = 2'd2
   } state_t;

endpackage

// File: rtl/icache_tag_store.sv
// Valid/tag flops with hit compare, single-line install and bulk invalidate.
module icache_tag_store
   import icache_array_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] lookup_idx,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             hit_c,
   input  logic             install,
   input  logic [IDX_W-1:0] install_idx,
   input  logic [TAG_W-1:0] install_tag,
   input  logic             inval_all
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags [NUM_LINES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
      end else if (inval_all) begin
         valid <= '0;
      end else if (install) begin
         valid[install_idx] <= 1'b1;
      end
   end

   // Tags carry no reset; the valid bit qualifies them.
   always_ff @(posedge clk) begin
      if (install) begin
         tags[install_idx] <= install_tag;
      end
   end

   assign hit_c = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);

endmodule

// File: rtl/isa.v
// Shared ISA-level widths used across the fetch path.
`ifndef ISA_V
`define ISA_V
`define XLEN           32
`define LINE_WORDS     4
`define OFFSET_BITS    2
`define LINE_BYTE_BITS 4
`endif

// File: rtl/icache_array.sv
// Direct-mapped I-cache: 1-cycle hits, miss -> refill -> replay of the stalled fetch.
module icache_array
   import icache_array_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   input  logic [XLEN-1:0] req_addr,
   input  logic            flush,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic            stall,
   output logic            cache_miss,
   output logic [XLEN-1:0] miss_addr,
   input  logic            refill_valid,
   input  logic [XLEN-1:0] refill_data,
   input  logic            refill_done
);

   state_t                 state, state_nxt;
   logic [OFFSET_BITS-1:0] word_cnt, word_cnt_nxt;
   logic                   flush_pending, flush_pending_nxt;
   logic                   resp_valid_nxt;
   logic [XLEN-1:0]        resp_data_nxt;
   logic                   cache_miss_nxt;
   logic [XLEN-1:0]        miss_addr_nxt;

   logic                   hit_c;
   logic                   lookup_hit;
   logic                   install;
   logic                   inval_all;
   logic                   data_we;
   logic [OFFSET_BITS-1:0] data_wr_off;

   logic [XLEN-1:0]        data_mem [NUM_LINES][LINE_WORDS];

   logic [IDX_W-1:0]       req_idx, miss_idx;
   logic [TAG_W-1:0]       req_tag, miss_tag;
   logic [OFFSET_BITS-1:0] req_off, miss_off;

   assign req_idx  = req_addr[LINE_BYTE_BITS +: IDX_W];
   assign req_tag  = req_addr[LINE_BYTE_BITS + IDX_W +: TAG_W];
   assign req_off  = req_addr[WORD_LSB +: OFFSET_BITS];
   assign miss_idx = miss_addr[LINE_BYTE_BITS +: IDX_W];
   assign miss_tag = miss_addr[LINE_BYTE_BITS + IDX_W +: TAG_W];
   assign miss_off = miss_addr[WORD_LSB +: OFFSET_BITS];

   icache_tag_store u_tag_store (
      .clk         (clk),
      .reset_n     (reset_n),
      .lookup_idx  (req_idx),
      .lookup_tag  (req_tag),
      .hit_c       (hit_c),
      .install     (install),
      .install_idx (miss_idx),
      .install_tag (miss_tag),
      .inval_all   (inval_all)
   );

   // A flush (new or deferred) makes this cycle's lookup miss.
   assign lookup_hit = hit_c & ~flush & ~flush_pending;
   assign stall      = (state != IDLE) | (req_valid & ~lookup_hit);

   always_comb begin
      state_nxt         = state;
      word_cnt_nxt      = word_cnt;
      flush_pending_nxt = flush_pending;
      resp_valid_nxt    = 1'b0;
      resp_data_nxt     = resp_data;
      cache_miss_nxt    = 1'b0;
      miss_addr_nxt     = miss_addr;
      install           = 1'b0;
      inval_all         = 1'b0;
      data_we           = 1'b0;
      data_wr_off       = word_cnt;

      case (state)
         IDLE: begin
            inval_all         = flush | flush_pending;
            flush_pending_nxt = 1'b0;
            if (req_valid) begin
               if (lookup_hit) begin
                  resp_valid_nxt = 1'b1;
                  resp_data_nxt  = data_mem[req_idx][req_off];
               end else begin
                  miss_addr_nxt  = req_addr;
                  cache_miss_nxt = 1'b1;
                  word_cnt_nxt   = '0;
                  state_nxt      = REFILL;
               end
            end
         end
         REFILL: begin
            if (flush) begin
               flush_pending_nxt = 1'b1;
            end
            if (refill_done) begin
               data_we     = 1'b1;
               data_wr_off = OFFSET_BITS'(LINE_WORDS - 1);
               install     = 1'b1;
               state_nxt   = REPLAY;
            end else if (refill_valid && (word_cnt != OFFSET_BITS'(LINE_WORDS - 1))) begin
               data_we      = 1'b1;
               word_cnt_nxt = word_cnt + OFFSET_BITS'(1);
            end
         end
         REPLAY: begin
            if (flush) begin
               flush_pending_nxt = 1'b1;
            end
            // Word 3 was written at the refill_done edge, so the array already holds it.
            resp_valid_nxt = 1'b1;
            resp_data_nxt  = data_mem[miss_idx][miss_off];
            state_nxt      = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         word_cnt      <= '0;
         flush_pending <= 1'b0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         cache_miss    <= 1'b0;
         miss_addr     <= '0;
      end else begin
         state         <= state_nxt;
         word_cnt      <= word_cnt_nxt;
         flush_pending <= flush_pending_nxt;
         resp_valid    <= resp_valid_nxt;
         resp_data     <= resp_data_nxt;
         cache_miss    <= cache_miss_nxt;
         miss_addr     <= miss_addr_nxt;
      end
   end

   // Line data is not reset; install order guarantees it is written before use.
   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[miss_idx][data_wr_off] <= refill_data;
      end
   end

endmodule

// File: tb/tb_icache_array.sv
// Directed bench for icache_array with queued expectations and a decoupled output monitor.
module tb_icache_array;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        flush;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        stall;
   logic        cache_miss;
   logic [31:0] miss_addr;
   logic        refill_valid;
   logic [31:0] refill_data;
   logic        refill_done;

   int checks = 0;
   int errors = 0;

   logic [31:0] resp_q[$];
   logic [31:0] miss_q[$];

   icache_array dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .flush        (flush),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .stall        (stall),
      .cache_miss   (cache_miss),
      .miss_addr    (miss_addr),
      .refill_valid (refill_valid),
      .refill_data  (refill_data),
      .refill_done  (refill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   // Monitor: compare every presented response / miss pulse against the queues.
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset_n) begin
         if (resp_valid) begin
            checks++;
            if (resp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: got resp_data %h, expected no response", resp_data);
            end else begin
               e = resp_q.pop_front();
               if (resp_data !== e) begin
                  errors++;
                  $display("FAIL resp_data: got %h, expected %h", resp_data, e);
               end
            end
         end
         if (cache_miss) begin
            checks++;
            if (miss_q.size() == 0) begin
               errors++;
               $display("FAIL miss_unexpected: got miss_addr %h, expected no miss pulse", miss_addr);
            end else begin
               e = miss_q.pop_front();
               if (miss_addr !== e) begin
                  errors++;
                  $display("FAIL miss_addr: got %h, expected %h", miss_addr, e);
               end
            end
         end
      end
   end

   task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp);
      req_valid = 1'b1;
      req_addr  = a;
      resp_q.push_back(exp);
      settle();
      chk("hit_stall", 32'(stall), 32'd0);
      tick();
      req_valid = 1'b0;
   endtask

   // Miss on a, n_valid refill_valid words (base+i, 4th one is junk), then refill_done with base+3.
   task automatic miss_fill(input logic [31:0] a, input logic [31:0] base, input int n_valid,
                            input logic flush_mid, input logic flush_now, input logic [31:0] exp);
      req_valid = 1'b1;
      req_addr  = a;
      flush     = flush_now;
      miss_q.push_back(a);
      settle();
      chk("miss_stall", 32'(stall), 32'd1);
      tick();
      flush = 1'b0;
      for (int i = 0; i < n_valid; i++) begin
         refill_valid = 1'b1;
         refill_data  = (i < 3) ? base + 32'(i) : base + 32'hF;
         flush        = flush_mid && (i == 1);
         settle();
         chk("refill_stall", 32'(stall), 32'd1);
         tick();
      end
      refill_valid = 1'b0;
      flush        = 1'b0;
      refill_done  = 1'b1;
      refill_data  = base + 32'd3;
      tick();
      refill_done = 1'b0;
      resp_q.push_back(exp);
      settle();
      chk("replay_stall", 32'(stall), 32'd1);
      tick();
      req_valid = 1'b0;
      settle();
      chk("replay_resp_valid", 32'(resp_valid), 32'd1);
      chk("post_replay_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_addr     = '0;
      flush        = 1'b0;
      refill_valid = 1'b0;
      refill_data  = '0;
      refill_done  = 1'b0;
      repeat (3) tick();
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_cache_miss", 32'(cache_miss), 32'd0);
      chk("rst_miss_addr", miss_addr, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      reset_n = 1'b1;
      tick();

      // Cold miss, then hits on the same line.
      miss_fill(32'h0000_0104, 32'hA0, 3, 1'b0, 1'b0, 32'hA1);
      fetch_hit(32'h0000_0100, 32'hA0);
      fetch_hit(32'h0000_0108, 32'hA2);
      fetch_hit(32'h0000_010C, 32'hA3);

      // Conflict on index 0, then the evicted line misses again.
      miss_fill(32'h0000_0904, 32'hB0, 3, 1'b0, 1'b0, 32'hB1);
      miss_fill(32'h0000_0104, 32'hA0, 3, 1'b0, 1'b0, 32'hA1);

      // Replay of word 3.
      miss_fill(32'h0000_020C, 32'hC0, 3, 1'b0, 1'b0, 32'hC3);

      // Extra refill_valid at saturated counter must be dropped.
      miss_fill(32'h0000_0310, 32'hD0, 4, 1'b0, 1'b0, 32'hD0);
      fetch_hit(32'h0000_0318, 32'hD2);
      fetch_hit(32'h0000_031C, 32'hD3);
      fetch_hit(32'h0000_0314, 32'hD1);

      // Early refill_done after a single word.
      miss_fill(32'h0000_0420, 32'hE0, 1, 1'b0, 1'b0, 32'hE0);
      fetch_hit(32'h0000_042C, 32'hE3);

      // Flush during refill: line is delivered, then invalidated.
      miss_fill(32'h0000_0530, 32'hF0, 3, 1'b1, 1'b0, 32'hF0);
      miss_fill(32'h0000_0530, 32'h70, 3, 1'b0, 1'b0, 32'h70);
      fetch_hit(32'h0000_0530, 32'h70);

      // Flush with a same-cycle request: treated as a miss.
      miss_fill(32'h0000_0530, 32'h80, 3, 1'b0, 1'b1, 32'h80);
      fetch_hit(32'h0000_0534, 32'h81);

      // Plain flush in IDLE.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      miss_fill(32'h0000_0534, 32'h90, 3, 1'b0, 1'b0, 32'h91);

      // Reset in the middle of a refill.
      req_valid = 1'b1;
      req_addr  = 32'h0000_0640;
      miss_q.push_back(32'h0000_0640);
      settle();
      chk("rr_miss_stall", 32'(stall), 32'd1);
      tick();
      req_valid    = 1'b0;
      refill_valid = 1'b1;
      refill_data  = 32'h40;
      tick();
      refill_data  = 32'h41;
      tick();
      refill_valid = 1'b0;
      reset_n      = 1'b0;
      settle();
      chk("rr_stall", 32'(stall), 32'd0);
      chk("rr_resp_valid", 32'(resp_valid), 32'd0);
      tick();
      reset_n      = 1'b1;
      refill_valid = 1'b1;
      refill_data  = 32'h99;
      tick();
      refill_valid = 1'b0;
      refill_done  = 1'b1;
      refill_data  = 32'h9A;
      tick();
      refill_done = 1'b0;
      settle();
      chk("rr_late_stall", 32'(stall), 32'd0);
      chk("rr_late_resp", 32'(resp_valid), 32'd0);
      tick();
      settle();
      chk("rr_late_resp2", 32'(resp_valid), 32'd0);
      miss_fill(32'h0000_0640, 32'h50, 3, 1'b0, 1'b0, 32'h50);
      miss_fill(32'h0000_0108, 32'h60, 3, 1'b0, 1'b0, 32'h62);

      repeat (3) tick();
      chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
      chk("miss_q_drained", 32'(miss_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
